fifo_rd_ctrl: RTL
=================

# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO. It lives in the read clock domain and pairs with a write-side controller and a dual-port RAM. It synchronises the incoming Gray write pointer and maintains the binary and Gray read pointers. It produces empty, almost-empty and level status, and returns read data in either standard mode or first-word-fall-through (FWFT) mode.

## Interface
- `DATA_WIDTH`, 8: read data width.
- `FIFO_DEPTH`, 64: number of entries. Must be a power of two ≥ 4; elaboration fails otherwise.
- `PTR_WIDTH`, `$clog2(FIFO_DEPTH)+1`: pointer width (address bits plus wrap bit).
- `SYNC_STAGES`, 2: flop stages on the write-pointer synchroniser, ≥ 2.
- `AEMPTY_THRESH`, 4: `almost_empty` asserts when `rd_level` ≤ this value.
- `FWFT`, 0: 0 selects standard mode, 1 selects first-word-fall-through.

Ports:
- `rd_clk`, in, 1: read clock; the only clock.
- `rd_rst_n`, in, 1: asynchronous, active-low reset.
- `rd_en`, in, 1: read request (standard mode) or pop (FWFT).
- `wr_ptr_gray`, in, PTR_WIDTH: Gray write pointer, driven from the write domain.
- `rd_ptr_gray`, out, PTR_WIDTH: registered Gray read pointer, sent to the write domain.
- `rd_addr`, out, PTR_WIDTH-1: RAM read address, equal to `rd_ptr[PTR_WIDTH-2:0]`.
- `ram_rd_data`, in, DATA_WIDTH: RAM output. This is a combinational read of `rd_addr`.
- `rd_data`, out, DATA_WIDTH: registered read data.
- `rd_valid`, out, 1: `rd_data` holds valid data.
- `empty`, out, 1: no unread entries in RAM.
- `almost_empty`, out, 1: RAM occupancy is at or below `AEMPTY_THRESH`.
- `rd_level`, out, PTR_WIDTH: RAM occupancy, range 0..FIFO_DEPTH.
- `underflow`, out, 1: one-cycle pulse on a rejected read.

## Operation
- **Synchroniser:** `wr_ptr_gray` passes through SYNC_STAGES flops, then is converted to binary to give `wr_bin_s`.
- **Status:**
  - `rd_level = (wr_bin_s - rd_ptr) mod 2^PTR_WIDTH`.
  - `empty = (rd_level == 0)`.
  - `almost_empty = (rd_level <= AEMPTY_THRESH)`.
  - All three are combinational from registers, so they are glitch-free per cycle.
- **Pointer advance:** a fetch increments `rd_ptr` by 1, wrapping modulo 2^PTR_WIDTH. The MSB toggles when `rd_addr` wraps from FIFO_DEPTH-1 to 0. `rd_ptr_gray` is registered from gray(next `rd_ptr`), so it changes on the same edge as `rd_ptr`.
- **Standard mode (FWFT=0):**
  - A read is accepted when `rd_en && !empty`.
  - On acceptance, `rd_data <= ram_rd_data`, the pointer advances, and `rd_valid` is 1 in the next cycle; otherwise `rd_valid` is 0.
  - `rd_data` holds its value when no read is accepted.
  - If `rd_en && empty`: `underflow` pulses and nothing changes.
- **FWFT mode (FWFT=1):** two-state FSM, OUT_EMPTY and OUT_VALID. `rd_valid` is 1 exactly in OUT_VALID.
  - OUT_EMPTY with `!empty`: load `rd_data`, advance the pointer, go to OUT_VALID. `rd_en` is not required.
  - OUT_VALID with `rd_en && !empty`: load the next word and advance, staying in OUT_VALID. This sustains one word per cycle.
  - OUT_VALID with `rd_en && empty`: go to OUT_EMPTY.
  - OUT_VALID with `!rd_en`: hold.
  - `rd_en` in OUT_EMPTY: `underflow` pulses.
  - `rd_level` and `empty` count RAM only; they exclude the word held in `rd_data`.
- **Reset (asynchronous, any time including mid-operation):**
  - `rd_ptr` = 0, `rd_ptr_gray` = 0, `rd_addr` = 0.
  - All synchroniser flops = 0.
  - `rd_data` = 0, `rd_valid` = 0, `underflow` = 0.
  - `rd_level` = 0, `empty` = 1, `almost_empty` = 1.
  - FSM = OUT_EMPTY.

## Timing
- A write-pointer change is visible on `empty`/`rd_level` after SYNC_STAGES `rd_clk` edges.
- Standard mode: `rd_data`/`rd_valid` appear 1 cycle after the accepted `rd_en`.
- FWFT: the first word appears 1 cycle after `empty` falls. Each pop costs 1 cycle.
- `rd_ptr_gray` updates on the same edge as `rd_ptr`. It changes by at most one bit per edge.
- `underflow` is asserted in the cycle after the rejected request, for exactly 1 cycle.

## Structure
- Package `fifo_pkg`:
  - `bin2gray` / `gray2bin` functions, parametrised on width.
  - FWFT state enum `{OUT_EMPTY, OUT_VALID}`.
  - Depth power-of-two check function.
- Sub-module `fifo_ptr_sync` (WIDTH, STAGES): asynchronous active-low reset flop chain. It is reused by the write-side controller.

## Test plan
All scenarios use DEPTH=8 (PTR_WIDTH=4), SYNC_STAGES=2, AEMPTY_THRESH=2.
- **Reset mid-stream:** assert `rd_rst_n`=0 during a burst of reads -> all outputs take reset values immediately, with no clock edge needed.
- **Standard fill:** set `wr_ptr_gray`=0010 (binary 3) -> after 2 edges `empty`=0, `rd_level`=3, `almost_empty`=0. Then three `rd_en` cycles -> `rd_data` = mem[0], mem[1], mem[2] with `rd_valid` high each time. `empty`=1 after the third.
- **Wrap:** start with `rd_ptr`=7 and `wr_bin_s`=10, one read -> `rd_ptr`=8, `rd_addr`=0, `rd_ptr_gray` 0100->1100, `rd_level` 3->2, `almost_empty`=1.
- **Full:** `wr_bin_s`=8, `rd_ptr`=0 -> `rd_level`=8, `empty`=0, `almost_empty`=0.
- **Underflow:** `rd_en`=1 while `empty` -> `underflow` pulses 1 cycle, pointers unchanged, `rd_valid`=0.
- **FWFT:** set `wr_ptr_gray`=gray(2) -> `rd_valid`=1 with mem[0], without `rd_en`. Hold `rd_en` -> mem[1] next cycle, then `rd_valid`=0 and `empty`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the asynchronous FIFO read/write controllers.
package fifo_pkg;

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_VALID = 1'b1} fwft_state_t;

  // Helpers work on a 32-bit zero-extended value; callers cast back to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic bit is_valid_depth(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing into this clock domain.
module fifo_ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: pointer sync, status, and standard/FWFT read data path.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 64,
  parameter int PTR_WIDTH     = $clog2(FIFO_DEPTH) + 1,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  rd_en,
  input  logic [PTR_WIDTH-1:0]  wr_ptr_gray,
  output logic [PTR_WIDTH-1:0]  rd_ptr_gray,
  output logic [PTR_WIDTH-2:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [PTR_WIDTH-1:0]  rd_level,
  output logic                  underflow
);

  if (!is_valid_depth(FIFO_DEPTH)) begin : g_bad_depth
    $error("fifo_rd_ctrl: FIFO_DEPTH must be a power of two >= 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_rd_ctrl: SYNC_STAGES must be >= 2");
  end

  logic [PTR_WIDTH-1:0]  w_wr_gray_s;
  logic [PTR_WIDTH-1:0]  w_wr_bin_s;
  logic [PTR_WIDTH-1:0]  w_rd_level;
  logic [PTR_WIDTH-1:0]  w_ptr_nxt;
  logic                  w_empty;
  logic                  w_fetch;
  logic                  w_uflow_req;

  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr_gray;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_underflow;
  fwft_state_t           r_state;

  fifo_ptr_sync #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .i_clk   (rd_clk),
    .i_rst_n (rd_rst_n),
    .i_d     (wr_ptr_gray),
    .o_q     (w_wr_gray_s)
  );

  assign w_wr_bin_s = PTR_WIDTH'(gray2bin(32'(w_wr_gray_s)));
  assign w_rd_level = w_wr_bin_s - r_rd_ptr;
  assign w_empty    = (w_rd_level == '0);
  assign w_ptr_nxt  = r_rd_ptr + 1'b1;

  // In FWFT the output register pulls a word on its own whenever it is empty.
  always_comb begin
    w_fetch     = 1'b0;
    w_uflow_req = 1'b0;
    if (FWFT != 0) begin
      w_fetch     = !w_empty && ((r_state == OUT_EMPTY) || rd_en);
      w_uflow_req = rd_en && (r_state == OUT_EMPTY);
    end else begin
      w_fetch     = rd_en && !w_empty;
      w_uflow_req = rd_en && w_empty;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_rd_ptr      <= '0;
      r_rd_ptr_gray <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_underflow   <= 1'b0;
      r_state       <= OUT_EMPTY;
    end else begin
      r_underflow <= w_uflow_req;
      if (w_fetch) begin
        r_rd_ptr      <= w_ptr_nxt;
        r_rd_ptr_gray <= PTR_WIDTH'(bin2gray(32'(w_ptr_nxt)));
        r_rd_data     <= ram_rd_data;
      end
      if (FWFT != 0) begin
        case (r_state)
          OUT_EMPTY: begin
            if (!w_empty) begin
              r_state    <= OUT_VALID;
              r_rd_valid <= 1'b1;
            end
          end
          OUT_VALID: begin
            if (rd_en && w_empty) begin
              r_state    <= OUT_EMPTY;
              r_rd_valid <= 1'b0;
            end
          end
          default: begin
            r_state    <= OUT_EMPTY;
            r_rd_valid <= 1'b0;
          end
        endcase
      end else begin
        r_rd_valid <= w_fetch;
      end
    end
  end

  assign rd_ptr_gray  = r_rd_ptr_gray;
  assign rd_addr      = r_rd_ptr[PTR_WIDTH-2:0];
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign empty        = w_empty;
  assign almost_empty = (32'(w_rd_level) <= 32'(AEMPTY_THRESH));
  assign rd_level     = w_rd_level;
  assign underflow    = r_underflow;

endmodule
